// File: rtl/t_toggle_scheduler_if.sv
// Configuration handshake bundle for t_toggle_scheduler: the register layer
// drives a channel write request and sees the accept/reject responses.
interface t_toggle_scheduler_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_en;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_period,
        output cfg_en,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_period,
        input  cfg_en,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/t_toggle_scheduler.sv
// Bank of NUM_CH programmable T flip-flops, each dividing clk by 2*(period+1),
// with config handshake, start/stop control and a stop sequence that parks q low.
module t_toggle_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    t_toggle_scheduler_if.slave cfg,
    input  logic                start,
    input  logic                stop,
    output logic                busy,
    output logic [NUM_CH-1:0]   t_out,
    output logic [NUM_CH-1:0]   q_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   period [NUM_CH];
    logic [CNT_W-1:0]   cnt    [NUM_CH];
    logic [NUM_CH-1:0]  en;
    logic [NUM_CH-1:0]  active;
    logic [NUM_CH-1:0]  ch_sel;
    logic               ch_ok;
    logic               cfg_wr;
    logic               cfg_bad;
    logic               launch;

    // Decode by equality so an out-of-range channel never indexes the arrays.
    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel[i] = (cfg.cfg_ch == CH_W'(i));
        end
    end

    assign ch_ok   = |ch_sel;
    assign cfg_wr  = (state == IDLE) && cfg.cfg_valid && ch_ok;
    assign cfg_bad = (state == IDLE) && cfg.cfg_valid && !ch_ok;
    assign launch  = (state == IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start)          state_nxt = RUN;
            RUN:      if (stop)           state_nxt = STOPPING;
            STOPPING: if (q_out == '0)    state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // While stopping, only channels still high keep counting toward their last toggle.
    always_comb begin
        cfg.cfg_ready = 1'b0;
        busy          = 1'b1;
        active        = '0;
        t_out         = '0;
        case (state)
            IDLE: begin
                cfg.cfg_ready = 1'b1;
                busy          = 1'b0;
            end
            RUN:      active = en;
            STOPPING: active = en & q_out;
            default:  active = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            t_out[i] = active[i] && (cnt[i] == period[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en          <= '0;
            q_out       <= '0;
            cfg.cfg_err <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            cfg.cfg_err <= cfg_bad;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_wr && ch_sel[i]) begin
                    period[i] <= cfg.cfg_period;
                    en[i]     <= cfg.cfg_en;
                end
                if (launch) begin
                    cnt[i]   <= '0;
                    q_out[i] <= 1'b0;
                end else if (t_out[i]) begin
                    cnt[i]   <= '0;
                    q_out[i] <= ~q_out[i];
                end else if (active[i]) begin
                    cnt[i]   <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_t_toggle_scheduler.sv
// Randomised and directed scoreboard bench for t_toggle_scheduler against an
// arithmetic model counting cycles each channel has spent counting.
module tb_t_toggle_scheduler;
    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int CHW = 3;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           stop  = 1'b0;
    logic           busy;
    logic [NCH-1:0] t_out;
    logic [NCH-1:0] q_out;

    t_toggle_scheduler_if #(.CH_W(CHW), .CNT_W(CW)) cfg_if ();

    t_toggle_scheduler #(.NUM_CH(NCH), .CNT_W(CW), .CH_W(CHW)) dut (
        .clk   (clk),
        .reset (reset),
        .cfg   (cfg_if),
        .start (start),
        .stop  (stop),
        .busy  (busy),
        .t_out (t_out),
        .q_out (q_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] t;
        logic [NCH-1:0] q;
        logic           busy;
        logic           ready;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Model: state 0 idle, 1 run, 2 stopping; m_n = cycles a channel has counted since start.
    int m_st;
    int m_p  [NCH];
    bit m_en [NCH];
    int m_n  [NCH];
    bit m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    function automatic bit m_q(int i);
        return ((m_n[i] / (m_p[i] + 1)) % 2) == 1;
    endfunction

    function automatic bit m_act(int i);
        return m_en[i] && (m_st == 1 || (m_st == 2 && m_q(i)));
    endfunction

    function automatic bit m_tog(int i);
        return m_act(i) && (((m_n[i] + 1) % (m_p[i] + 1)) == 0);
    endfunction

    function automatic logic [NCH-1:0] m_qvec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_q(i);
        return v;
    endfunction

    task automatic model_reset();
        m_st  = 0;
        m_err = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_p[i]  = 0;
            m_en[i] = 1'b0;
            m_n[i]  = 0;
        end
    endtask

    // One clock cycle: predict outputs, queue them, drive inputs, advance model.
    task automatic cyc(input bit v, input int ch, input int p, input bit e,
                       input bit s, input bit sp);
        exp_t x;
        bit   act [NCH];
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            x.t[i] = m_tog(i);
            x.q[i] = m_q(i);
            act[i] = m_act(i);
        end
        x.busy  = (m_st != 0);
        x.ready = (m_st == 0);
        x.err   = m_err;
        sb.push_back(x);

        cfg_if.cfg_valid  = v;
        cfg_if.cfg_ch     = 3'(ch);
        cfg_if.cfg_period = 8'(p);
        cfg_if.cfg_en     = e;
        start             = s;
        stop              = sp;

        m_err = (m_st == 0) && v && (ch >= NCH);
        case (m_st)
            0: begin
                if (v && ch < NCH) begin
                    m_p[ch]  = p;
                    m_en[ch] = e;
                end
                if (s) begin
                    for (int i = 0; i < NCH; i++) m_n[i] = 0;
                    m_st = 1;
                end
            end
            1: begin
                for (int i = 0; i < NCH; i++) if (act[i]) m_n[i]++;
                if (sp) m_st = 2;
            end
            default: begin
                for (int i = 0; i < NCH; i++) if (act[i]) m_n[i]++;
                if (x.q == '0) begin
                    m_st = 0;
                    for (int i = 0; i < NCH; i++) m_n[i] = 0;
                end
            end
        endcase
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int ch, input int p, input bit e);
        cyc(1, ch, p, e, 0, 0);
    endtask

    task automatic finish_stop(input bit hold);
        int k = 0;
        while (m_st != 0 && k < 600) begin
            cyc(0, 0, 0, 0, 0, hold);
            k++;
        end
        chk("stop_completes", 32'(m_st), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_q_out"},     32'(q_out),            32'd0);
        chk({tag, "_t_out"},     32'(t_out),            32'd0);
        chk({tag, "_busy"},      32'(busy),             32'd0);
        chk({tag, "_cfg_ready"}, 32'(cfg_if.cfg_ready), 32'd1);
        chk({tag, "_cfg_err"},   32'(cfg_if.cfg_err),   32'd0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk("t_out",     32'(t_out),            32'(x.t));
            chk("q_out",     32'(q_out),            32'(x.q));
            chk("busy",      32'(busy),             32'(x.busy));
            chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(x.ready));
            chk("cfg_err",   32'(cfg_if.cfg_err),   32'(x.err));
        end
    end

    initial begin
        int k;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_ch     = '0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_en     = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("reset_init");
        @(negedge clk);
        reset = 1'b1;

        // ch0 P=0, ch1 P=2; a write attempted during RUN must be ignored
        cfg(0, 0, 1);
        cfg(1, 2, 1);
        cfg(2, 0, 0);
        cfg(3, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle(12);
        cfg(1, 7, 1);
        idle(6);
        cyc(0, 0, 0, 0, 0, 1);
        finish_stop(0);

        // out-of-range channels are rejected with an error pulse
        cfg(5, 9, 1);
        idle(1);
        cfg(7, 3, 0);
        idle(2);
        cyc(0, 0, 0, 0, 1, 0);
        idle(9);
        cyc(0, 0, 0, 0, 0, 1);
        finish_stop(0);

        // orderly stop issued while ch1 is high with its counter at 1, stop held
        cfg(1, 3, 1);
        cyc(0, 0, 0, 0, 1, 0);
        k = 0;
        while (!(m_q(1) && (m_n[1] % 4) == 1) && k < 50) begin
            idle(1);
            k++;
        end
        chk("orderly_stop_setup", 32'(k < 50), 32'd1);
        finish_stop(1);
        idle(2);

        // no channel enabled: single STOPPING cycle
        for (int i = 0; i < NCH; i++) cfg(i, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        finish_stop(0);

        // enabled but all q still low at stop
        cfg(3, 5, 1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        finish_stop(0);

        // full-range period on ch2
        cfg(3, 0, 0);
        cfg(2, 255, 1);
        cyc(0, 0, 0, 0, 1, 0);
        idle(262);
        cyc(0, 0, 0, 0, 0, 1);
        finish_stop(0);

        // start and stop together in IDLE: start wins
        cfg(2, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        idle(4);
        cyc(0, 0, 0, 0, 0, 1);
        finish_stop(0);

        // async reset mid-RUN with q_out = 0101
        cfg(0, 2, 1);
        cfg(1, 0, 0);
        cfg(2, 2, 1);
        cfg(3, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        k = 0;
        while (m_qvec() != 4'b0101 && k < 50) begin
            idle(1);
            k++;
        end
        chk("reset_run_setup", 32'(k < 50), 32'd1);
        @(posedge clk);
        #2;
        cfg_if.cfg_valid = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid_run");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(3);

        // randomised traffic
        for (int n = 0; n < 2500; n++) begin
            cyc(($urandom % 4) == 0, int'($urandom % 8), int'($urandom % 8),
                ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 16) == 0);
        end
        finish_stop(1);
        idle(3);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
